// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache with 128-bit lines and a 0-cycle hit path.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module l1_dcache #(
  parameter int unsigned SET_BITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);
  localparam int unsigned SETS    = 1 << SET_BITS;
  localparam int unsigned TAG_W   = 12 - SET_BITS;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned LADDR_W = 12;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_e;

  state_e               state_q, state_d;
  logic [LADDR_W-1:0]   laddr_q, laddr_d;
  logic                 valid_q [SETS];
  logic                 dirty_q [SETS];
  logic [TAG_W-1:0]     tag_q   [SETS];
  logic [LINE_W-1:0]    data_q  [SETS];

  logic [SET_BITS-1:0]  req_idx, lat_idx, meta_idx, data_idx;
  logic [TAG_W-1:0]     req_tag, lat_tag, meta_tag_d;
  logic [2:0]           word_sel;
  logic                 req, hit;
  logic                 meta_we, meta_dirty_d, data_we;
  logic [LINE_W-1:0]    cur_line, data_line_d;
  logic [15:0]          rd_word, wr_word;
  logic                 unused_addr_bit;

  assign req_idx         = mem_address[3+SET_BITS:4];
  assign req_tag         = mem_address[15:4+SET_BITS];
  assign word_sel        = mem_address[3:1];
  assign unused_addr_bit = mem_address[0];
  assign lat_idx         = laddr_q[SET_BITS-1:0];
  assign lat_tag         = laddr_q[LADDR_W-1:SET_BITS];

  assign req      = mem_read | mem_write;
  assign cur_line = data_q[req_idx];
  assign hit      = req & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign rd_word  = cur_line[{word_sel, 4'b0000} +: 16];
  assign wr_word  = {mem_byte_enable[1] ? mem_wdata[15:8] : rd_word[15:8],
                     mem_byte_enable[0] ? mem_wdata[7:0]  : rd_word[7:0]};

  // Next-state, handshake outputs and array update controls
  always_comb begin
    state_d      = state_q;
    laddr_d      = laddr_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    meta_we      = 1'b0;
    meta_idx     = req_idx;
    meta_dirty_d = 1'b0;
    meta_tag_d   = req_tag;
    data_we      = 1'b0;
    data_idx     = req_idx;
    data_line_d  = cur_line;

    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          mem_resp = 1'b1;
          if (mem_write) begin
            data_line_d[{word_sel, 4'b0000} +: 16] = wr_word;
            data_we      = 1'b1;
            meta_we      = 1'b1;
            meta_dirty_d = 1'b1;
          end else begin
            mem_rdata = rd_word;
          end
        end else if (req) begin
          // Latch the line address; the miss sequence works from it until IDLE
          laddr_d = mem_address[15:4];
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[lat_idx], lat_idx, 4'b0000};
        pmem_wdata   = data_q[lat_idx];
        if (pmem_resp) begin
          meta_we      = 1'b1;
          meta_idx     = lat_idx;
          meta_dirty_d = 1'b0;
          meta_tag_d   = tag_q[lat_idx];
          state_d      = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {laddr_q, 4'b0000};
        if (pmem_resp) begin
          data_we      = 1'b1;
          data_idx     = lat_idx;
          data_line_d  = pmem_rdata;
          meta_we      = 1'b1;
          meta_idx     = lat_idx;
          meta_dirty_d = 1'b0;
          meta_tag_d   = lat_tag;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      laddr_q <= '0;
      for (int unsigned i = 0; i < SETS; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      laddr_q <= laddr_d;
      if (meta_we) begin
        valid_q[meta_idx] <= 1'b1;
        dirty_q[meta_idx] <= meta_dirty_d;
        tag_q[meta_idx]   <= meta_tag_d;
      end
    end
  end

  // Line storage is deliberately left unreset; valid bits guard its contents
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[data_idx] <= data_line_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;
  logic        post_fill_q, post_fill_d;

  // The hit that completes a filled request is not a first-presentation hit
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    post_fill_d  = (state_q == S_ALLOCATE) && pmem_resp;
    if ((state_q == S_IDLE) && hit && !post_fill_q && (hit_count_q != 16'hFFFF)) begin
      hit_count_d = hit_count_q + 16'd1;
    end
    if ((state_q == S_IDLE) && req && !hit && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      post_fill_q  <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      post_fill_q  <= post_fill_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed scoreboard bench for l1_dcache; stimulus queues expected responses,
// independent monitors compare CPU responses and pmem transactions as the DUT presents them.
`timescale 1ns/1ps
module tb_l1_dcache;
  logic         clk;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
`ifdef DCACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  l1_dcache #(.SET_BITS(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic chk; logic [15:0] data; string name; } mexp_t;
  typedef struct { logic is_wr; logic [15:0] addr; logic [127:0] wdata; string name; } pexp_t;
  typedef struct { int lat; logic [127:0] line; } svc_t;

  mexp_t mexp_q[$];
  pexp_t pexp_q[$];
  svc_t  svc_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  localparam logic [127:0] L1 = 128'h7777_6666_5555_4444_3333_BEEF_1111_0000;
  localparam logic [127:0] V1 = 128'h7777_6666_5555_4444_3333_A5EF_1111_0034;
  localparam logic [127:0] L2 = 128'h0F0F_0E0E_0D0D_0C0C_0B0B_CAFE_0909_0808;
  localparam logic [127:0] L3 = 128'h3737_3636_3535_3434_3A3B_3232_3131_3030;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CPU response monitor
  initial begin : mem_mon
    mexp_t e;
    forever begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        if (mexp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_mem_resp: got mem_resp=1 addr %0h expected no response", mem_address);
        end else begin
          e = mexp_q.pop_front();
          if (e.chk) check(e.name, 128'(mem_rdata), 128'(e.data));
        end
      end
    end
  end

  // pmem transaction monitor: checks each new strobe and the address held at pmem_resp
  initial begin : pmem_mon
    logic [1:0] prev;
    logic [1:0] cur;
    pexp_t e;
    pexp_t last;
    prev = 2'b00;
    last = '{1'b0, 16'h0, 128'h0, "none"};
    forever begin
      @(negedge clk);
      cur = {pmem_write, pmem_read};
      if (cur != 2'b00 && cur != prev) begin
        if (pexp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pmem: got strobes %b addr %0h expected none", cur, pmem_address);
        end else begin
          e = pexp_q.pop_front();
          last = e;
          check($sformatf("%s_kind", e.name), 128'(cur), e.is_wr ? 128'd2 : 128'd1);
          check($sformatf("%s_addr", e.name), 128'(pmem_address), 128'(e.addr));
          if (e.is_wr) check($sformatf("%s_wdata", e.name), pmem_wdata, e.wdata);
        end
      end else if (cur != 2'b00 && pmem_resp === 1'b1) begin
        check($sformatf("%s_hold_addr", last.name), 128'(pmem_address), 128'(last.addr));
      end
      prev = cur;
    end
  end

  // pmem responder: pmem_resp is sampled on the lat-th edge after the strobe rises
  initial begin : responder
    svc_t s;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if ((pmem_read || pmem_write) && svc_q.size() > 0) begin
        s = svc_q.pop_front();
        repeat (s.lat - 1) @(posedge clk);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = s.line;
      end
    end
  end

  task automatic do_req(input logic [15:0] a, input logic rd, input logic wr,
                        input logic [1:0] be, input logic [15:0] wd, output int cyc);
    @(posedge clk);
    #1;
    mem_address = a; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
    cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        cyc = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name, input int lat);
    int cyc;
    mexp_q.push_back('{1'b1, exp, name});
    do_req(a, 1'b1, 1'b0, 2'b00, 16'h0, cyc);
    check($sformatf("%s_lat", name), 128'(cyc), 128'(lat));
  endtask

  task automatic wr(input logic [15:0] a, input logic rdalso, input logic [1:0] be,
                    input logic [15:0] d, input string name);
    int cyc;
    mexp_q.push_back('{1'b0, 16'h0, name});
    do_req(a, rdalso, 1'b1, be, d, cyc);
    check($sformatf("%s_lat", name), 128'(cyc), 128'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b0;
    mem_address = 16'h1234; mem_read = 1'b1; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_wdata = 16'h0;
    #12;
    check("rst_mem_resp",   128'(mem_resp),   128'd0);
    check("rst_mem_rdata",  128'(mem_rdata),  128'd0);
    check("rst_pmem_read",  128'(pmem_read),  128'd0);
    check("rst_pmem_write", 128'(pmem_write), 128'd0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Cold miss, clean fill
    pexp_q.push_back('{1'b0, 16'h1230, 128'h0, "cold_fill"});
    svc_q.push_back('{5, L1});
    rd(16'h1234, 16'hBEEF, "cold_rd", 6);
    rd(16'h1236, 16'h3333, "hit_w3", 0);

    // Sub-word writes
    wr(16'h1234, 1'b0, 2'b10, 16'hA55A, "wr_hi");
    rd(16'h1234, 16'hA5EF, "rd_after_wr_hi", 0);
    wr(16'h1238, 1'b0, 2'b00, 16'hFFFF, "wr_be0");
    rd(16'h1238, 16'h4444, "rd_after_be0", 0);
    wr(16'h1230, 1'b0, 2'b01, 16'h1234, "wr_lo");
    rd(16'h1231, 16'h0034, "rd_lo_odd_addr", 0);

    // Dirty victim: writeback then fill
    pexp_q.push_back('{1'b1, 16'h1230, V1, "wb"});
    pexp_q.push_back('{1'b0, 16'h2230, 128'h0, "wb_fill"});
    svc_q.push_back('{3, 128'h0});
    svc_q.push_back('{4, L2});
    rd(16'h2234, 16'hCAFE, "dirty_miss", 8);

    // Reset in the middle of ALLOCATE
    pexp_q.push_back('{1'b0, 16'h1230, 128'h0, "rst_fill"});
    @(posedge clk);
    #1;
    mem_address = 16'h1234; mem_read = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_pmem_read", 128'(pmem_read), 128'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_pmem_read",  128'(pmem_read),  128'd0);
    check("mid_rst_pmem_write", 128'(pmem_write), 128'd0);
    check("mid_rst_mem_resp",   128'(mem_resp),   128'd0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    pexp_q.push_back('{1'b0, 16'h2230, 128'h0, "post_rst_fill"});
    svc_q.push_back('{2, L2});
    rd(16'h2234, 16'hCAFE, "post_rst_rd", 3);
    pexp_q.push_back('{1'b0, 16'h1230, 128'h0, "post_rst_fill2"});
    svc_q.push_back('{2, L1});
    rd(16'h1234, 16'hBEEF, "post_rst_rd2", 3);

    // Request dropped mid-ALLOCATE: fill completes, no response
    pexp_q.push_back('{1'b0, 16'h3230, 128'h0, "drop_fill"});
    svc_q.push_back('{4, L3});
    @(posedge clk);
    #1;
    mem_address = 16'h3234; mem_read = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    repeat (8) @(posedge clk);
    rd(16'h3236, 16'h3A3B, "after_drop_hit", 0);

    // Read and write together behaves as a write
    wr(16'h3236, 1'b1, 2'b11, 16'h5A5A, "rw_both");
    rd(16'h3236, 16'h5A5A, "rd_after_rw_both", 0);

`ifdef DCACHE_STATS_EN
    pulse_reset();
    check("stats_rst_hit",  128'(hit_count),  128'd0);
    check("stats_rst_miss", 128'(miss_count), 128'd0);
    pexp_q.push_back('{1'b0, 16'h1230, 128'h0, "stats_fill1"});
    svc_q.push_back('{2, L1});
    rd(16'h1234, 16'hBEEF, "stats_miss1", 3);
    rd(16'h1234, 16'hBEEF, "stats_hit1", 0);
    rd(16'h1236, 16'h3333, "stats_hit2", 0);
    pexp_q.push_back('{1'b0, 16'h2230, 128'h0, "stats_fill2"});
    svc_q.push_back('{2, L2});
    rd(16'h2234, 16'hCAFE, "stats_miss2", 3);
    check("stats_hit_count",  128'(hit_count),  128'd2);
    check("stats_miss_count", 128'(miss_count), 128'd2);
`endif

    repeat (3) @(posedge clk);
    check("mexp_drained", 128'(mexp_q.size()), 128'd0);
    check("pexp_drained", 128'(pexp_q.size()), 128'd0);
    check("svc_drained",  128'(svc_q.size()),  128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
